// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage and the decode-register wrapper.
package cpu_pkg;

    localparam int              ADDR_W   = 32;
    localparam logic [31:0]     RESET_PC = 32'h0000_0000;
    localparam logic [31:0]     NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc_plus4;
        logic              valid;
    } fetch_out_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory read port: registered address out, data returns one cycle later.
interface inst_fetch_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// Skid register holding the fetch output across a stall, plus the fetch output mux.
module fetch_skid_buf #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              release_i,
    input  logic              clear_i,
    input  logic [31:0]       rdata_i,
    input  logic [ADDR_W-1:0] resp_pc_i,
    input  logic              resp_valid_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o
);

    logic              hold_valid_q, hold_valid_d;
    logic [31:0]       hold_inst_q;
    logic [ADDR_W-1:0] hold_pc_q;

    // Capturing a bubble leaves the skid empty so the output keeps showing NOP.
    always_comb begin
        hold_valid_d = hold_valid_q;
        if (clear_i || release_i) begin
            hold_valid_d = 1'b0;
        end else if (capture_i) begin
            hold_valid_d = resp_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture_i && !clear_i) begin
            hold_inst_q <= rdata_i;
            hold_pc_q   <= resp_pc_i;
        end
    end

    always_comb begin
        inst_o  = NOP_INST;
        pc_o    = resp_pc_i;
        valid_o = 1'b0;
        if (hold_valid_q) begin
            inst_o  = hold_inst_q;
            pc_o    = hold_pc_q;
            valid_o = 1'b1;
        end else if (resp_valid_i) begin
            inst_o  = rdata_i;
            pc_o    = resp_pc_i;
            valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC sequencing, branch redirect and stall handling in front of a 1-cycle imem.
module inst_fetch #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0]       NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stallF,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    inst_fetch_if.master      imem,
    output logic [31:0]       inst_f,
    output logic [ADDR_W-1:0] pc_f,
    output logic [ADDR_W-1:0] pc_plus4_f,
    output logic              valid_f
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_req_q, pc_req_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic              resp_valid_q, resp_valid_d;

    logic              hold_capture, hold_release, hold_clear;
    logic [31:0]       skid_inst;
    logic [ADDR_W-1:0] skid_pc;
    logic              skid_valid;

    logic [ADDR_W-1:0] target_aligned;
    logic [1:0]        unused_target_lsb;

    assign target_aligned    = {branch_target[ADDR_W-1:2], 2'b00};
    assign unused_target_lsb = branch_target[1:0];

    // Redirect outranks stall; the word already in flight for the old path is dropped.
    always_comb begin
        state_d      = state_q;
        pc_req_d     = pc_req_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        hold_capture = 1'b0;
        hold_release = 1'b0;
        hold_clear   = 1'b0;

        if (branch_taken) begin
            pc_req_d     = target_aligned;
            resp_pc_d    = pc_req_q;
            resp_valid_d = 1'b0;
            hold_clear   = 1'b1;
            state_d      = RUN;
        end else begin
            case (state_q)
                BOOT: begin
                    pc_req_d     = pc_req_q + PC_STEP;
                    resp_pc_d    = pc_req_q;
                    resp_valid_d = 1'b1;
                    state_d      = RUN;
                end
                RUN: begin
                    if (stallF) begin
                        // pc_req stays put so the memory keeps re-reading the successor.
                        hold_capture = 1'b1;
                        resp_pc_d    = pc_req_q;
                        state_d      = HOLD;
                    end else begin
                        pc_req_d     = pc_req_q + PC_STEP;
                        resp_pc_d    = pc_req_q;
                        resp_valid_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stallF) begin
                        hold_release = 1'b1;
                        pc_req_d     = pc_req_q + PC_STEP;
                        resp_pc_d    = pc_req_q;
                        resp_valid_d = 1'b1;
                        state_d      = RUN;
                    end
                end
                default: begin
                    pc_req_d     = RESET_PC;
                    resp_pc_d    = RESET_PC;
                    resp_valid_d = 1'b0;
                    state_d      = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_req_q     <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_req_q     <= pc_req_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign imem.imem_addr = pc_req_q;

    fetch_skid_buf #(
        .ADDR_W   (ADDR_W),
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk          (clk),
        .rst          (reset),
        .capture_i    (hold_capture),
        .release_i    (hold_release),
        .clear_i      (hold_clear),
        .rdata_i      (imem.imem_rdata),
        .resp_pc_i    (resp_pc_q),
        .resp_valid_i (resp_valid_q),
        .inst_o       (skid_inst),
        .pc_o         (skid_pc),
        .valid_o      (skid_valid)
    );

    // Registers still hold pre-reset contents during the reset cycle, so mask them here.
    always_comb begin
        inst_f  = skid_inst;
        pc_f    = skid_pc;
        valid_f = skid_valid;
        if (reset) begin
            inst_f  = NOP_INST;
            pc_f    = RESET_PC;
            valid_f = 1'b0;
        end
    end

    assign pc_plus4_f = pc_f + PC_STEP;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: synchronous memory model plus an instruction-stream reference model.
module tb_inst_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallF = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] inst_f, pc_f, pc_plus4_f;
    logic        valid_f;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    string tag   = "init";

    // Reference model: the PC decode must receive next, and whether a bubble is due.
    logic [31:0] exp_pc = RESET_PC;
    bit          forced = 1'b1;
    bit          boot   = 1'b1;

    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32)) imem ();

    inst_fetch #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stallF        (stallF),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem.master),
        .inst_f        (inst_f),
        .pc_f          (pc_f),
        .pc_plus4_f    (pc_plus4_f),
        .valid_f       (valid_f)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) imem.imem_rdata <= mem_word(imem.imem_addr);

    task automatic step(input bit s, input bit b, input logic [31:0] t, input bit r);
        fetch_out_t got, exp;
        bit chk_pc, bad;
        stallF = s; branch_taken = b; branch_target = t; reset = r;
        #1;
        got = '{inst: inst_f, pc: pc_f, pc_plus4: pc_plus4_f, valid: valid_f};
        exp = '{inst: NOP_INST, pc: RESET_PC, pc_plus4: RESET_PC + 32'd4, valid: 1'b0};
        chk_pc = 1'b1;
        if (!r) begin
            if (forced) begin
                chk_pc = boot;
            end else begin
                exp.inst     = mem_word(exp_pc);
                exp.pc       = exp_pc;
                exp.pc_plus4 = exp_pc + 32'd4;
                exp.valid    = 1'b1;
            end
        end
        bad = (got.valid !== exp.valid) || (got.inst !== exp.inst) ||
              (chk_pc && ((got.pc !== exp.pc) || (got.pc_plus4 !== exp.pc_plus4)));
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s cyc %0d: got valid=%0b pc=%h pc4=%h inst=%h, expected valid=%0b pc=%h pc4=%h inst=%h%s",
                     tag, cyc, got.valid, got.pc, got.pc_plus4, got.inst,
                     exp.valid, exp.pc, exp.pc_plus4, exp.inst, chk_pc ? "" : " (pc not checked)");
        end
        @(posedge clk);
        if (r) begin
            forced = 1'b1; boot = 1'b1; exp_pc = RESET_PC;
        end else if (b) begin
            forced = 1'b1; boot = 1'b0; exp_pc = {t[31:2], 2'b00};
        end else if (forced) begin
            forced = !boot && s; boot = 1'b0;
        end else if (!s) begin
            exp_pc = exp_pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        tag = "reset";
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (valid_f !== 1'b1 || pc_f !== RESET_PC) begin
            fails++;
            $display("FAIL reset_first: valid_f=%0b pc_f=%h, expected 1 and %h", valid_f, pc_f, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        tag = "sequential";
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (pc_f !== 32'(i * 4) || inst_f !== 32'h1000_0000 + 32'(i)) begin
                fails++;
                $display("FAIL seq_%0d: pc_f=%h inst_f=%h, expected %h %h",
                         i, pc_f, inst_f, 32'(i * 4), 32'h1000_0000 + 32'(i));
            end
            step(1'b0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_stall();
        tag = "stall";
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (pc_f !== 32'h8 || inst_f !== 32'h1000_0002 || valid_f !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold_%0d: pc_f=%h inst_f=%h valid_f=%0b, expected 8 10000002 1",
                         i, pc_f, inst_f, valid_f);
            end
            step(i < 3, 1'b0, 32'h0, 1'b0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_branch();
        tag = "branch";
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0);
        tests++;
        if (valid_f !== 1'b0) begin
            fails++;
            $display("FAIL branch_bubble: valid_f=%0b, expected 0", valid_f);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (pc_f !== 32'h40 || inst_f !== 32'h1000_0010) begin
            fails++;
            $display("FAIL branch_target: pc_f=%h inst_f=%h, expected 40 10000010", pc_f, inst_f);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_branch_in_hold();
        tag = "branch_in_hold";
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h80, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (pc_f !== 32'h80 || valid_f !== 1'b1 || inst_f !== 32'h1000_0020) begin
            fails++;
            $display("FAIL hold_branch_target: pc_f=%h valid_f=%0b inst_f=%h, expected 80 1 10000020",
                     pc_f, valid_f, inst_f);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_in_hold();
        tag = "reset_in_hold";
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h100, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h43, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (pc_f !== 32'h40 || inst_f !== 32'h1000_0010) begin
            fails++;
            $display("FAIL masked_target: pc_f=%h inst_f=%h, expected 40 10000010", pc_f, inst_f);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        tag = "wrap";
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (pc_f !== 32'hFFFF_FFFC || pc_plus4_f !== 32'h0) begin
            fails++;
            $display("FAIL wrap_plus4: pc_f=%h pc_plus4_f=%h, expected fffffffc 0", pc_f, pc_plus4_f);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        tests++;
        if (pc_f !== 32'h0 || valid_f !== 1'b1) begin
            fails++;
            $display("FAIL wrap_next: pc_f=%h valid_f=%0b, expected 0 1", pc_f, valid_f);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        tag = "random";
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit s, b, r;
            logic [31:0] t;
            s = ($urandom_range(0, 99) < 35);
            b = ($urandom_range(0, 99) < 10);
            r = ($urandom_range(0, 99) < 2);
            t = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            step(s, b, t, r);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_in_hold();
        test_reset_in_hold();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
